div_seq: RTL
============

# div_seq

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU path. It performs restoring division through repeated trial subtraction, one quotient bit per clock, with a start/done handshake. It returns both quotient and remainder with RISC-V semantics for divide-by-zero and signed overflow. It sits beside the ALU; the pipeline/control stalls on `o_busy`.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported for RV32.
- `i_clk` in 1: clock. Single clock domain.
- `i_reset` in 1: synchronous, active-high reset.
- `i_start` in 1: request. Sampled only when the block is not busy.
- `i_signed` in 1: 1 selects DIV/REM (two's complement); 0 selects DIVU/REMU.
- `i_dividend` in WIDTH: dividend. Latched on accept.
- `i_divisor` in WIDTH: divisor. Latched on accept.
- `o_quotient` out WIDTH: quotient. Valid while `o_done`=1; held until the next accept.
- `o_remainder` out WIDTH: remainder. Valid and held as for `o_quotient`.
- `o_busy` out 1: high from the cycle after accept through the FIX state.
- `o_done` out 1: single-cycle pulse; results valid.

## Operation
- States are IDLE, CALC, FIX and DONE.
  - IDLE: `i_start`=1 → accept.
    - Latch `i_signed`.
    - Latch the magnitudes of the operands. In signed mode, negate negative operands; in unsigned mode, use them raw.
    - Record the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)).
    - Clear the partial remainder R (WIDTH+1 bits).
    - Load Q with |dividend|.
    - Set the iteration counter to 0.
    - Go to CALC.
  - CALC: each cycle performs one iteration.
    - Shift {R,Q} left by one.
    - Compute D = R − {0,|divisor|} using the 33-bit subtractor.
    - If D is non-negative (MSB=0): R ← D and Q[0] ← 1. Otherwise R is unchanged and Q[0] ← 0.
    - The counter increments. After iteration 31 (the 32nd), go to FIX.
  - FIX: apply the special cases and sign correction.
    - Divisor==0: quotient = all ones (0xFFFF_FFFF), remainder = original dividend, in both modes. This overrides sign correction.
    - Signed overflow (0x8000_0000 / 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0. The normal path produces this result; verification checks it explicitly.
    - Otherwise: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set and the remainder is non-zero.
    - Write the output registers and go to DONE.
  - DONE: `o_done`=1 for one cycle.
    - Next state is IDLE.
    - If `i_start`=1 in DONE, the request is accepted exactly as in IDLE and the next state is CALC.
- `i_start` while in CALC or FIX is ignored. No queuing.
- Arithmetic:
  - R is WIDTH+1 bits so the trial subtraction never loses the borrow.
  - Negation is bitwise invert plus 1, performed mod 2^WIDTH.
- The remainder sign always follows the dividend, and |remainder| < |divisor| whenever the divisor ≠ 0.

## Timing
- Accept happens at rising edge k, which samples `i_start`=1 in IDLE or DONE.
- Edges k+1 … k+32 perform the 32 CALC iterations.
- Edge k+33 performs FIX.
- `o_done`=1 during the cycle after edge k+33, and deasserts at edge k+34 unless a back-to-back accept occurs.
- Fixed latency: 34 cycles from the accept cycle to the `o_done` cycle, independent of operands and special cases.
- `o_busy`=1 from after edge k through the FIX cycle; 0 in IDLE and DONE.
- Reset values: `o_quotient`=0, `o_remainder`=0, `o_busy`=0, `o_done`=0, state=IDLE, counter=0.
- Reset mid-operation (CALC or FIX) aborts on the same edge: IDLE with all outputs at their reset values, and no `o_done`.
- `i_reset` takes priority over `i_start` on the same edge.

## Structure
- Package `div_pkg`:
  - `DIV_WIDTH`=32.
  - State enum `div_state_e` (IDLE, CALC, FIX, DONE).
  - Counter width constant $clog2(`DIV_WIDTH`).
- Sub-module `sub_33bit`: combinational WIDTH+1-bit subtractor computing A + ~B + 1, with a borrow-out. It is instantiated once for the trial subtraction.
- The two's-complement negations in accept and FIX may reuse inline logic. No second adder instance is required.

## Test plan
- Unsigned 100 / 7: `i_signed`=0, dividend 0x64, divisor 0x7. Expect `o_done` 34 cycles after the accept cycle, quotient 0xE, remainder 0x2, `o_busy` high for exactly 33 cycles.
- Signed −7 / 2: dividend 0xFFFF_FFF9, divisor 0x2. Expect quotient 0xFFFF_FFFD (−3), remainder 0xFFFF_FFFF (−1). With `i_signed`=0, the same operands give quotient 0x7FFF_FFFC, remainder 0x1.
- Divide-by-zero: dividend 0x1234_5678, divisor 0. In both modes, expect quotient 0xFFFF_FFFF, remainder 0x1234_5678, and the same 34-cycle latency.
- Signed overflow: dividend 0x8000_0000, divisor 0xFFFF_FFFF, signed. Expect quotient 0x8000_0000, remainder 0.
- Handshake:
  - Pulse `i_start` with new operands at CALC cycle 10; it must be ignored and the first result unchanged.
  - Assert `i_start` in the DONE cycle with operands 9 / 3; expect the next `o_done` exactly 34 cycles later with quotient 3, remainder 0.
- Reset: assert `i_reset` for one cycle at CALC cycle 20. Next cycle: `o_busy`=0, outputs 0, and no `o_done` for 40 cycles. A fresh start then completes normally.

Source files
------------

// File: rtl/div_seq_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared width, counter and state definitions for div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int CNT_W     = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // Two's-complement negation, wrapping modulo 2^DIV_WIDTH.
   function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] v);
      return ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_seq_if.sv
// ============================================================================
// Module      : div_seq_if
// Description : Start/done request and result bundle of the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic             i_signed;
   logic [WIDTH-1:0] i_dividend;
   logic [WIDTH-1:0] i_divisor;
   logic [WIDTH-1:0] o_quotient;
   logic [WIDTH-1:0] o_remainder;
   logic             o_busy;
   logic             o_done;

   modport master (
      output i_start, i_signed, i_dividend, i_divisor,
      input  o_quotient, o_remainder, o_busy, o_done
   );

   modport slave (
      input  i_start, i_signed, i_dividend, i_divisor,
      output o_quotient, o_remainder, o_busy, o_done
   );
endinterface

`default_nettype wire

// File: rtl/div_seq_sub_33bit.sv
// ============================================================================
// Module      : sub_33bit
// Description : Combinational A - B as A + ~B + 1, with borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_33bit #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);
   logic w_carry;

   assign {w_carry, diff} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
   // No carry out of A + ~B + 1 means B > A.
   assign borrow = ~w_carry;
endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module      : div_seq
// Description : Restoring 32-bit divider, one quotient bit per clock, RV32M semantics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic      i_clk,
   input  logic      i_reset,
   div_seq_if.slave  bus
);
   div_state_e         r_state;
   div_state_e         w_state_nxt;
   logic               w_accept;

   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_dsr;
   logic [WIDTH-1:0]   r_dvd_raw;
   logic               r_div0;
   logic               r_qsign;
   logic               r_rsign;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_q_out;
   logic [WIDTH-1:0]   r_r_out;

   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_borrow;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = CALC;
            end
         end
         CALC: if (r_cnt == C_LAST) w_state_nxt = FIX;
         FIX:  w_state_nxt = DONE;
         DONE: begin
            w_state_nxt = IDLE;
            if (bus.i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = CALC;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_a_mag = (bus.i_signed && bus.i_dividend[WIDTH-1]) ? negate(bus.i_dividend) : bus.i_dividend;
   assign w_b_mag = (bus.i_signed && bus.i_divisor[WIDTH-1])  ? negate(bus.i_divisor)  : bus.i_divisor;

   // {R,Q} shifted left by one; the old R MSB is always 0 because R < divisor.
   assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};

   sub_33bit #(.W(WIDTH + 1)) u_sub (
      .a      (w_shift),
      .b      ({1'b0, r_dsr}),
      .diff   (w_diff),
      .borrow (w_borrow)
   );

   // Divide-by-zero overrides sign correction; overflow falls out naturally.
   assign w_q_fix = r_div0  ? '1 :
                    r_qsign ? negate(r_quo) : r_quo;
   assign w_r_fix = r_div0 ? r_dvd_raw :
                    (r_rsign && (r_rem[WIDTH-1:0] != '0)) ? negate(r_rem[WIDTH-1:0]) :
                    r_rem[WIDTH-1:0];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rem     <= '0;
         r_quo     <= '0;
         r_dsr     <= '0;
         r_dvd_raw <= '0;
         r_div0    <= 1'b0;
         r_qsign   <= 1'b0;
         r_rsign   <= 1'b0;
         r_cnt     <= '0;
         r_q_out   <= '0;
         r_r_out   <= '0;
      end else if (w_accept) begin
         r_rem     <= '0;
         r_quo     <= w_a_mag;
         r_dsr     <= w_b_mag;
         r_dvd_raw <= bus.i_dividend;
         r_div0    <= (bus.i_divisor == '0);
         r_qsign   <= bus.i_signed & (bus.i_dividend[WIDTH-1] ^ bus.i_divisor[WIDTH-1]);
         r_rsign   <= bus.i_signed & bus.i_dividend[WIDTH-1];
         r_cnt     <= '0;
      end else if (r_state == CALC) begin
         r_rem <= w_borrow ? w_shift : w_diff;
         r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == FIX) begin
         r_q_out <= w_q_fix;
         r_r_out <= w_r_fix;
      end
   end

   assign bus.o_quotient  = r_q_out;
   assign bus.o_remainder = r_r_out;
   assign bus.o_busy      = (r_state == CALC) || (r_state == FIX);
   assign bus.o_done      = (r_state == DONE);
endmodule

`default_nettype wire
